// File: rtl/baud_tick_gen_if.sv
// Divisor update channel for baud_tick_gen: a requested integer/fractional
// divisor pair moved with a valid/ready handshake.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_valid;
  logic              div_ready;

  modport master (
    output div_int,
    output div_frac,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_int,
    input  div_frac,
    input  div_valid,
    output div_ready
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: oversample tick plus bit tick, with a divisor
// shadow applied on bit boundaries. Define BAUD_RESYNC_EN to add the resync input.
module baud_tick_gen #(
  parameter int DIV_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 651,
  parameter int DEFAULT_DIV_FRAC = 1
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                en,
`ifdef BAUD_RESYNC_EN
  input  logic                resync,
`endif
  baud_tick_gen_if.slave      div_if,
  output logic                tick,
  output logic                bit_tick,
  output logic [DIV_W-1:0]    cur_div_int,
  output logic [FRAC_W-1:0]   cur_div_frac
);

  localparam int SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0]  SUB_MID  = SUB_W'(OVERSAMPLE / 2);

  if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("OVERSAMPLE must be a power of two and at least 2");
  end

  typedef enum logic {
    UPD_IDLE,
    UPD_PENDING
  } upd_state_e;

  upd_state_e        upd_q, upd_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;

  logic [DIV_W:0]    limit;
  logic [FRAC_W:0]   acc_sum;
  logic              period_end;
  logic              bit_end;
  logic              resync_hit;
  logic              accept;
  logic              apply;

  // The carry from the previous period stretches this one by a single cycle.
  assign limit      = {1'b0, act_int_q} + {{DIV_W{1'b0}}, extra_q};
  assign acc_sum    = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign period_end = en && ({1'b0, cnt_q} == (limit - (DIV_W+1)'(1)));
  assign bit_end    = period_end && (sub_q == SUB_LAST);

`ifdef BAUD_RESYNC_EN
  assign resync_hit = en && resync;
`else
  assign resync_hit = 1'b0;
`endif

  // A resync suppresses the pulses but not the bit boundary used for apply.
  assign tick     = period_end && !resync_hit;
  assign bit_tick = bit_end && !resync_hit;

  assign div_if.div_ready = (upd_q == UPD_IDLE);
  assign accept = div_if.div_valid && (upd_q == UPD_IDLE);
  assign apply  = (upd_q == UPD_PENDING) && (!en || bit_end);

  assign cur_div_int  = act_int_q;
  assign cur_div_frac = act_frac_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and infers a latch.
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    extra_d       = extra_q;
    sub_d         = sub_q;
    upd_d         = upd_q;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    act_int_d     = act_int_q;
    act_frac_d    = act_frac_q;

    if (!en) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      sub_d   = '0;
    end else if (resync_hit) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      sub_d   = SUB_MID;
    end else if (period_end) begin
      cnt_d   = '0;
      acc_d   = acc_sum[FRAC_W-1:0];
      extra_d = acc_sum[FRAC_W];
      sub_d   = sub_q + SUB_W'(1);
    end else begin
      cnt_d   = cnt_q + DIV_W'(1);
    end

    if (accept) begin
      shadow_int_d  = (div_if.div_int < MIN_DIV) ? MIN_DIV : div_if.div_int;
      shadow_frac_d = div_if.div_frac;
      upd_d         = UPD_PENDING;
    end

    // The new divisor starts from a clean fractional phase.
    if (apply) begin
      act_int_d  = shadow_int_q;
      act_frac_d = shadow_frac_q;
      acc_d      = '0;
      extra_d    = 1'b0;
      upd_d      = UPD_IDLE;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      upd_q         <= UPD_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      extra_q       <= 1'b0;
      sub_q         <= '0;
      shadow_int_q  <= RST_INT;
      shadow_frac_q <= RST_FRAC;
      act_int_q     <= RST_INT;
      act_frac_q    <= RST_FRAC;
    end else begin
      upd_q         <= upd_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      extra_q       <= extra_d;
      sub_q         <= sub_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      act_int_q     <= act_int_d;
      act_frac_q    <= act_frac_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: stimulus queues the expected tick stream,
// a negedge monitor pops and compares each tick the DUT produces.
module tb_baud_tick_gen;

  logic        clk_100MHz;
  logic        reset;
  logic        en;
  logic        resync;
  logic        tick;
  logic        bit_tick;
  logic [15:0] cur_div_int;
  logic [3:0]  cur_div_frac;

  baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) div_if ();

  baud_tick_gen #(
    .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16),
    .DEFAULT_DIV_INT(651), .DEFAULT_DIV_FRAC(1)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .en           (en),
`ifdef BAUD_RESYNC_EN
    .resync       (resync),
`endif
    .div_if       (div_if.slave),
    .tick         (tick),
    .bit_tick     (bit_tick),
    .cur_div_int  (cur_div_int),
    .cur_div_frac (cur_div_frac)
  );

  typedef struct {
    int period;
    bit bt;
    int ci;
    int cf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_ref = 0;
  logic en_prev  = 1'b0;

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int p, input bit b, input int ci, input int cf);
    exp_t e;
    e.period = p;
    e.bt     = b;
    e.ci     = ci;
    e.cf     = cf;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wait_level(input int level, input int max_cycles, input string name);
    int n = 0;
    while (exp_q.size() > level && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_q.size() > level) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d ticks outstanding, expected at most %0d", name, exp_q.size(), level);
      exp_q.delete();
    end
  endtask

  // Divisor load while disabled: applies on the cycle after acceptance.
  task automatic load(input int di, input int df, input int exp_i, input int exp_f);
    div_if.div_int   = 16'(di);
    div_if.div_frac  = 4'(df);
    div_if.div_valid = 1'b1;
    step();
    div_if.div_valid = 1'b0;
    check("ready_low_while_pending", div_if.div_ready, 0);
    step();
    check("load_cur_div_int", cur_div_int, exp_i);
    check("load_cur_div_frac", cur_div_frac, exp_f);
    check("load_ready_restored", div_if.div_ready, 1);
  endtask

  // Monitor: tick periods are measured from the previous tick, the cycle
  // before en rose, or the resync cycle.
  always @(negedge clk_100MHz) begin
    exp_t e;
    if (en && !en_prev) last_ref = cyc - 1;
`ifdef BAUD_RESYNC_EN
    if (en && resync) last_ref = cyc;
`endif
    en_prev = en;
    if (tick || bit_tick) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick=%0b bit_tick=%0b, expected none (cycle %0d)", tick, bit_tick, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick_period", cyc - last_ref, e.period);
        check("tick_level", tick, 1);
        check("bit_tick", bit_tick, e.bt);
        check("tick_cur_div_int", cur_div_int, e.ci);
        check("tick_cur_div_frac", cur_div_frac, e.cf);
      end
      last_ref = cyc;
    end
  end

  initial begin
    reset            = 1'b1;
    en               = 1'b0;
    resync           = 1'b0;
    div_if.div_int   = '0;
    div_if.div_frac  = '0;
    div_if.div_valid = 1'b0;
    repeat (3) step();

    check("rst_tick", tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_div_ready", div_if.div_ready, 1);
    check("rst_cur_div_int", cur_div_int, 651);
    check("rst_cur_div_frac", cur_div_frac, 1);
    reset = 1'b0;
    step();

    // Defaults: fifteen 651-cycle periods, bit tick on the 16th, then one 652.
    en = 1'b1;
    for (int i = 1; i <= 17; i++) push((i == 17) ? 652 : 651, i == 16, 651, 1);
    step();
    check("run_div_ready", div_if.div_ready, 1);
    wait_level(0, 12000, "default_run");
    en = 1'b0;
    step();

    // Integer 4/0 from a cold enable.
    load(4, 0, 4, 0);
    en = 1'b1;
    for (int i = 1; i <= 32; i++) push(4, (i % 16) == 0, 4, 0);
    wait_level(0, 300, "int4_run");

    // Mid-bit update to 6/0; a second request while pending is ignored.
    for (int i = 1; i <= 16; i++) push(4, i == 16, 4, 0);
    for (int i = 1; i <= 16; i++) push(6, i == 16, 6, 0);
    repeat (5) step();
    div_if.div_int   = 16'd6;
    div_if.div_frac  = 4'd0;
    div_if.div_valid = 1'b1;
    step();
    div_if.div_valid = 1'b0;
    check("ready_low_after_accept", div_if.div_ready, 0);
    repeat (13) step();
    check("ready_low_mid_bit", div_if.div_ready, 0);
    div_if.div_int   = 16'd9;
    div_if.div_valid = 1'b1;
    step();
    div_if.div_valid = 1'b0;
    wait_level(0, 400, "update_run");
    check("update_ready_restored", div_if.div_ready, 1);
    check("update_cur_div_int", cur_div_int, 6);
    en = 1'b0;
    step();

    // Fractional 4 + 8/16: periods 4,4,5,4,5,...
    load(4, 8, 4, 8);
    en = 1'b1;
    for (int k = 1; k <= 16; k++) push((k >= 3 && (k % 2) == 1) ? 5 : 4, k == 16, 4, 8);
    wait_level(0, 300, "frac_run");
    en = 1'b0;
    step();

    // Clamp 1 -> 2, then reset mid-period with an update pending.
    load(1, 0, 2, 0);
    en = 1'b1;
    for (int i = 1; i <= 9; i++) push(2, 1'b0, 2, 0);
    wait_level(1, 100, "clamp_run");
    div_if.div_int   = 16'd5;
    div_if.div_frac  = 4'd0;
    div_if.div_valid = 1'b1;
    step();
    div_if.div_valid = 1'b0;
    wait_level(0, 100, "clamp_tail");
    check("ready_low_before_reset", div_if.div_ready, 0);
    reset = 1'b1;
    step();
    check("midrst_tick", tick, 0);
    check("midrst_bit_tick", bit_tick, 0);
    check("midrst_cur_div_int", cur_div_int, 651);
    check("midrst_cur_div_frac", cur_div_frac, 1);
    check("midrst_div_ready", div_if.div_ready, 1);
    reset = 1'b0;
    en    = 1'b0;
    repeat (5) step();
    check("pending_discarded", cur_div_int, 651);

`ifdef BAUD_RESYNC_EN
    // Resync on a would-be tick cycle: realigns to mid-bit.
    load(4, 0, 4, 0);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) push(4, 1'b0, 4, 0);
    wait_level(0, 100, "resync_pre");
    repeat (3) step();
    resync = 1'b1;
    for (int i = 1; i <= 8; i++) push(4, i == 8, 4, 0);
    step();
    resync = 1'b0;
    wait_level(0, 100, "resync_post");
    en = 1'b0;
`endif

    repeat (10) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
